cpu_perf_monitor: RTL and testbench

Passive hardware performance monitor on the CPU side of the shared memory bus. It samples pc, read, write and halted every CPU clock and counts cycles, retired instructions, memory reads and memory writes until the CPU halts. It then computes cycles-per-instruction in fixed point with a sequential divider. This moves the measurement that the simulation bench does today into synthesizable hardware, so it can be read out on silicon or FPGA.

---
 rtl/cpu_perf_pkg.sv | 35 +++
 rtl/cpu_perf_monitor_divider.sv | 130 +++++++++++++
 rtl/cpu_perf_monitor.sv | 154 +++++++++++++++
 tb/tb_cpu_perf_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_perf_pkg.sv
// Shared definitions for the CPU performance monitor.
//   perf_state_e      : measurement state machine encoding
//   DEFAULT_*         : default counter/fraction widths and divider length
//   div_iters()       : divider iteration count for a given width pair
//   sat_inc()         : increment that sticks at a supplied maximum
package cpu_perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DIVIDE,
    DONE
  } perf_state_e;

  localparam int DEFAULT_CNT_WIDTH = 32;
  localparam int DEFAULT_FRAC_BITS = 16;
  localparam int DEFAULT_DIV_ITERS = DEFAULT_CNT_WIDTH + DEFAULT_FRAC_BITS;

  // One quotient bit per iteration over the whole shifted dividend.
  function automatic int div_iters(input int cnt_w, input int frac_b);
    return cnt_w + frac_b;
  endfunction

  // Values are carried at 64 bits so one function serves every counter
  // width up to 64; callers cast back to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_val,
                                          input logic        en);
    if (en && (value != max_val)) begin
      return value + 64'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/cpu_perf_monitor_divider.sv
// perf_divider: sequential restoring unsigned divider, MSB first.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   start_i          : 1-cycle pulse; samples dividend_i/divisor_i and
//                      performs the first iteration on the same edge
//   abort_i          : drops any division in progress
//   dividend_i       : DIVIDEND_W-bit dividend
//   divisor_i        : DIVISOR_W-bit divisor
//   busy_o           : iterations still outstanding
//   valid_o          : 1-cycle pulse, quotient_o/overflow_o meaningful
//   quotient_o       : low QUOT_W bits of the quotient
//   overflow_o       : quotient does not fit QUOT_W bits, or divide by zero
// A division takes DIVIDEND_W start-to-valid edges; divide by zero
// reports overflow on the start edge itself. DIVIDEND_W must exceed QUOT_W.
module perf_divider
  import cpu_perf_pkg::*;
#(
  parameter int DIVIDEND_W = DEFAULT_DIV_ITERS,
  parameter int DIVISOR_W  = DEFAULT_CNT_WIDTH,
  parameter int QUOT_W     = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  overflow_o,
  output logic [QUOT_W-1:0]     quotient_o
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  // quot_q starts as the dividend and shifts quotient bits in from the
  // right, so after the last step it holds the full quotient.
  logic [DIVISOR_W-1:0]  rem_q,     rem_d;
  logic [DIVIDEND_W-1:0] quot_q,    quot_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic                  busy_q,    busy_d;
  logic                  valid_q,   valid_d;
  logic                  div0_q,    div0_d;

  logic [DIVISOR_W-1:0]  rem_src;
  logic [DIVIDEND_W-1:0] quot_src;
  logic [DIVISOR_W-1:0]  dsr_src;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  rem_step;
  logic [DIVIDEND_W-1:0] quot_step;
  logic                  qbit;

  // One restoring step, fed from the inputs on the start edge.
  always_comb begin
    rem_src  = start_i ? '0         : rem_q;
    quot_src = start_i ? dividend_i : quot_q;
    dsr_src  = start_i ? divisor_i  : divisor_q;
    trial    = {rem_src, quot_src[DIVIDEND_W-1]};
    if (trial >= {1'b0, dsr_src}) begin
      // remainder < divisor guarantees the difference fits DIVISOR_W bits
      rem_step = DIVISOR_W'(trial - {1'b0, dsr_src});
      qbit     = 1'b1;
    end else begin
      rem_step = trial[DIVISOR_W-1:0];
      qbit     = 1'b0;
    end
    quot_step = {quot_src[DIVIDEND_W-2:0], qbit};
  end

  always_comb begin
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    div0_d    = div0_q;
    if (abort_i) begin
      busy_d = 1'b0;
      div0_d = 1'b0;
    end else if (start_i) begin
      divisor_d = divisor_i;
      if (divisor_i == '0) begin
        valid_d = 1'b1;
        div0_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = CW'(DIVIDEND_W - 1);
        div0_d = 1'b0;
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      div0_q    <= div0_d;
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign quotient_o = quot_q[QUOT_W-1:0];
  assign overflow_o = div0_q | (|quot_q[DIVIDEND_W-1:QUOT_W]);

endmodule

// File: rtl/cpu_perf_monitor.sv
// cpu_perf_monitor: passive CPU-side performance monitor.
//   clk_i, reset_i    : CPU clock, asynchronous active-high reset
//   clear_i           : synchronous pulse, back to IDLE with zeroed results
//   pc_i, read_i, write_i, halted_i : sampled CPU bus activity
//   measuring_o       : high while counting
//   done_o            : high once cpi_o is final; everything then holds
//   cycles_o, instructions_o, mem_reads_o, mem_writes_o : saturating counts
//   cpi_o             : cycles/instructions, Q(CNT_WIDTH-FRAC_BITS).FRAC_BITS
// Counting starts one edge after leaving reset/clear and stops on the
// first edge that sees halted_i; the divider then runs to produce cpi_o.
module cpu_perf_monitor
  import cpu_perf_pkg::*;
#(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic                 halted_i,
  output logic                 measuring_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic [CNT_WIDTH-1:0] instructions_o,
  output logic [CNT_WIDTH-1:0] mem_reads_o,
  output logic [CNT_WIDTH-1:0] mem_writes_o,
  output logic [CNT_WIDTH-1:0] cpi_o
);

  localparam int DIV_W = div_iters(CNT_WIDTH, FRAC_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  perf_state_e          state_q,     state_d;
  logic [CNT_WIDTH-1:0] cycles_q,    cycles_d;
  logic [CNT_WIDTH-1:0] instr_q,     instr_d;
  logic [CNT_WIDTH-1:0] reads_q,     reads_d;
  logic [CNT_WIDTH-1:0] writes_q,    writes_d;
  logic [CNT_WIDTH-1:0] cpi_q,       cpi_d;
  logic [PC_WIDTH-1:0]  last_pc_q,   last_pc_d;
  logic                 measuring_q, measuring_d;
  logic                 done_q,      done_d;

  logic                 div_start;
  logic                 div_busy;
  logic                 div_valid;
  logic                 div_ovf;
  logic                 div_done;
  logic [CNT_WIDTH-1:0] div_quot;

  perf_divider #(
    .DIVIDEND_W (DIV_W),
    .DIVISOR_W  (CNT_WIDTH),
    .QUOT_W     (CNT_WIDTH)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (reset_i),
    .start_i    (div_start),
    .abort_i    (clear_i),
    .dividend_i ({cycles_q, {FRAC_BITS{1'b0}}}),
    .divisor_i  (instr_q),
    .busy_o     (div_busy),
    .valid_o    (div_valid),
    .overflow_o (div_ovf),
    .quotient_o (div_quot)
  );

  // valid and busy are exclusive; gating on both keeps a result from being
  // taken while the divider still believes it is iterating.
  assign div_done = div_valid & ~div_busy;

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    instr_d   = instr_q;
    reads_d   = reads_q;
    writes_d  = writes_q;
    cpi_d     = cpi_q;
    last_pc_d = last_pc_q;
    div_start = 1'b0;
    if (clear_i) begin
      state_d   = IDLE;
      cycles_d  = '0;
      instr_d   = '0;
      reads_d   = '0;
      writes_d  = '0;
      cpi_d     = '0;
      last_pc_d = '1;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (halted_i) begin
            state_d   = DIVIDE;
            div_start = 1'b1;
          end else begin
            cycles_d  = CNT_WIDTH'(sat_inc(64'(cycles_q), 64'(CNT_MAX), 1'b1));
            reads_d   = CNT_WIDTH'(sat_inc(64'(reads_q),  64'(CNT_MAX), read_i));
            writes_d  = CNT_WIDTH'(sat_inc(64'(writes_q), 64'(CNT_MAX), write_i));
            instr_d   = CNT_WIDTH'(sat_inc(64'(instr_q),  64'(CNT_MAX),
                                           pc_i != last_pc_q));
            last_pc_d = pc_i;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            state_d = DONE;
            cpi_d   = div_ovf ? CNT_MAX : div_quot;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    measuring_d = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      instr_q     <= '0;
      reads_q     <= '0;
      writes_q    <= '0;
      cpi_q       <= '0;
      last_pc_q   <= '1;
      measuring_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      instr_q     <= instr_d;
      reads_q     <= reads_d;
      writes_q    <= writes_d;
      cpi_q       <= cpi_d;
      last_pc_q   <= last_pc_d;
      measuring_q <= measuring_d;
      done_q      <= done_d;
    end
  end

  assign measuring_o    = measuring_q;
  assign done_o         = done_q;
  assign cycles_o       = cycles_q;
  assign instructions_o = instr_q;
  assign mem_reads_o    = reads_q;
  assign mem_writes_o   = writes_q;
  assign cpi_o          = cpi_q;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
module tb_cpu_perf_monitor;

  localparam int S_IDLE = 0, S_RUN = 1, S_DIV = 2, S_DONE = 3;

  typedef struct {
    int     st;
    longint cyc;
    longint ins;
    longint rd;
    longint wr;
    longint last_pc;
    int     left;
    longint cpi;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [9:0] pc = '0;
  logic       rd = 1'b0, wr = 1'b0, halted = 1'b0;

  logic        meas0, done0;
  logic [31:0] cyc0, ins0, rd0, wr0, cpi0;
  logic        meas4, done4;
  logic [3:0]  cyc4, ins4, rd4, wr4, cpi4;

  int n_vec = 0;
  int n_bad = 0;

  mdl_t m0, m4;

  always #5 clk = ~clk;

  cpu_perf_monitor #(.PC_WIDTH(10), .CNT_WIDTH(32), .FRAC_BITS(16)) u_dut (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .pc_i(pc),
    .read_i(rd), .write_i(wr), .halted_i(halted),
    .measuring_o(meas0), .done_o(done0), .cycles_o(cyc0),
    .instructions_o(ins0), .mem_reads_o(rd0), .mem_writes_o(wr0), .cpi_o(cpi0)
  );

  cpu_perf_monitor #(.PC_WIDTH(10), .CNT_WIDTH(4), .FRAC_BITS(2)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .pc_i(pc),
    .read_i(rd), .write_i(wr), .halted_i(halted),
    .measuring_o(meas4), .done_o(done4), .cycles_o(cyc4),
    .instructions_o(ins4), .mem_reads_o(rd4), .mem_writes_o(wr4), .cpi_o(cpi4)
  );

  // ---------------- behavioural model ----------------
  function automatic mdl_t m_init();
    mdl_t m;
    m.st = S_IDLE; m.cyc = 0; m.ins = 0; m.rd = 0; m.wr = 0;
    m.last_pc = 1023; m.left = 0; m.cpi = 0;
    return m;
  endfunction

  function automatic mdl_t m_step(mdl_t mi, int cw, int fb, logic [9:0] p,
                                  logic r, logic w, logic h, logic c);
    mdl_t   m = mi;
    longint mx = (longint'(1) << cw) - 1;
    longint q;
    if (c) return m_init();
    case (m.st)
      S_IDLE: m.st = S_RUN;
      S_RUN: begin
        if (h) begin
          m.st   = S_DIV;
          m.left = (m.ins == 0) ? 1 : cw + fb;
        end else begin
          if (m.cyc < mx) m.cyc++;
          if (r && m.rd < mx) m.rd++;
          if (w && m.wr < mx) m.wr++;
          if (longint'(p) != m.last_pc && m.ins < mx) m.ins++;
          m.last_pc = longint'(p);
        end
      end
      S_DIV: begin
        m.left--;
        if (m.left == 0) begin
          m.st = S_DONE;
          if (m.ins == 0) m.cpi = mx;
          else begin
            q = (m.cyc << fb) / m.ins;
            m.cpi = (q > mx) ? mx : q;
          end
        end
      end
      default: ;
    endcase
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= m_init();
      m4 <= m_init();
    end else begin
      m0 <= m_step(m0, 32, 16, pc, rd, wr, halted, clear);
      m4 <= m_step(m4, 4, 2, pc, rd, wr, halted, clear);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [63:0] c,
                     input logic [63:0] i, input logic [63:0] r, input logic [63:0] w,
                     input logic [63:0] q, input logic ms, input logic dn);
    chk({tag, ".measuring"}, {63'd0, ms}, {63'd0, m.st == S_RUN});
    chk({tag, ".done"}, {63'd0, dn}, {63'd0, m.st == S_DONE});
    chk({tag, ".cycles"}, c, m.cyc);
    chk({tag, ".instructions"}, i, m.ins);
    chk({tag, ".mem_reads"}, r, m.rd);
    chk({tag, ".mem_writes"}, w, m.wr);
    chk({tag, ".cpi"}, q, m.cpi);
  endtask

  always @(negedge clk) begin
    cmp("dut32", m0, cyc0, ins0, rd0, wr0, cpi0, meas0, done0);
    cmp("dut4", m4, cyc4, ins4, rd4, wr4, cpi4, meas4, done4);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic [9:0] p, input logic r, input logic w,
                     input logic h, input logic c);
    pc = p; rd = r; wr = w; halted = h; clear = c;
    tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) $display("FAIL wait_done: got timeout expected done within 200 cycles");
  endtask

  task automatic check_run(input string t, input int lat, input longint c,
                           input longint i, input longint r, input longint w,
                           input longint q, input longint q4);
    int n;
    wait_done(n);
    chk({t, ".latency"}, n, lat);
    chk({t, ".cycles"}, cyc0, c);
    chk({t, ".instructions"}, ins0, i);
    chk({t, ".mem_reads"}, rd0, r);
    chk({t, ".mem_writes"}, wr0, w);
    chk({t, ".cpi"}, cpi0, q);
    chk({t, ".cpi4"}, cpi4, q4);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst.cycles", cyc0, 0);
    chk("rst.measuring", meas0, 0);
    chk("rst.done", done0, 0);
    chk("rst.cpi", cpi0, 0);
    reset = 1'b0;

    // T1: pc 0..9 then halt
    cyc(0, 0, 0, 0, 0);  // IDLE -> RUN edge
    for (int i = 0; i < 10; i++) cyc(10'(i), 0, 0, 0, 0);
    cyc(9, 0, 0, 1, 0);
    check_run("t1", 48, 10, 10, 0, 0, 64'h0001_0000, 4);
    cyc(9, 0, 0, 0, 0);  // halted dropping leaves DONE alone
    cyc(9, 0, 0, 0, 0);
    chk("t1.done_hold", done0, 1);

    // T2: pc 0,0,1,1,2,2,3,3 with reads on 2,5 and write on 7
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(10'((i - 1) / 2), i == 2 || i == 5, i == 7, 0, 0);
    cyc(3, 0, 0, 1, 0);
    check_run("t2", 48, 8, 4, 2, 1, 64'h0002_0000, 8);

    // T3: halted from the first RUN edge -> divide by zero
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check_run("t3", 1, 0, 0, 0, 0, 64'hFFFF_FFFF, 4'hF);

    // T4: async reset mid-RUN
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 5; i < 8; i++) cyc(10'(i), 1, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("t4.async_cycles", cyc0, 0);
    chk("t4.async_reads", rd0, 0);
    chk("t4.async_measuring", meas0, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(2, 0, 1, 0, 0);
    cyc(2, 0, 0, 1, 0);
    check_run("t4", 48, 2, 2, 0, 2, 64'h0001_0000, 4);

    // T5: clear 10 cycles into DIVIDE, then an independent run
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(10'(i), 1, 1, 0, 0);
    cyc(3, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(3, 0, 0, 1, 0);
    cyc(3, 0, 0, 0, 1);
    chk("t5.clr_done", done0, 0);
    chk("t5.clr_cpi", cpi0, 0);
    chk("t5.clr_cycles", cyc0, 0);
    chk("t5.clr_measuring", meas0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(10'(i / 3), 0, 0, 0, 0);
    chk("t5.no_done", done0, 0);
    cyc(1, 0, 0, 1, 0);
    check_run("t5", 48, 6, 2, 0, 0, 64'h0003_0000, 12);

    // T6: 20 cycles pc toggling, read and write together; 4-bit build saturates
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(10'(i % 2), 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    check_run("t6", 48, 20, 20, 20, 20, 64'h0001_0000, 4);
    chk("t6.cycles4", cyc4, 15);
    chk("t6.instructions4", ins4, 15);
    chk("t6.reads4", rd4, 15);
    chk("t6.writes4", wr4, 15);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
